// File: rtl/i2s_rx_pkg.sv
// rtl/i2s_rx_pkg.sv - shared constants and FSM state type for the I2S receiver
package i2s_rx_pkg;

    localparam int DEF_SMPL_W = 24;
    localparam int DEF_SLOT_W = 32;

    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_SKIP_L = 3'd1,
        ST_LEFT   = 3'd2,
        ST_WAIT_R = 3'd3,
        ST_SKIP_R = 3'd4,
        ST_RIGHT  = 3'd5,
        ST_WAIT_L = 3'd6
    } rx_state_e;

endpackage

// File: rtl/i2s_edge_sync.sv
// rtl/i2s_edge_sync.sv - two-flop synchronizer plus history flop for one async input
module i2s_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic sig_sync,
    output logic sig_hist
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic hist_q, hist_d;

    always_comb begin
        meta_d = sig_in;
        sync_d = meta_q;
        hist_d = sync_q;
    end

    // Reset value matches the idle line level so no edge appears at reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            hist_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign sig_sync = sync_q;
    assign sig_hist = hist_q;

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S serial receiver producing framed signed stereo sample pairs
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int SMPL_W = DEF_SMPL_W,
    parameter int SLOT_W = DEF_SLOT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I2S_sclk,
    input  logic              I2S_ws,
    input  logic              I2S_data,
    output logic [SMPL_W-1:0] lft_chnnl,
    output logic [SMPL_W-1:0] rght_chnnl,
    output logic              vld,
    output logic              sync_err
);

    localparam int CNT_W = $clog2(SMPL_W + 1);
    localparam int unused_slot_pad = SLOT_W - SMPL_W - 1;

    logic sclk_s, sclk_h, ws_s, ws_h, data_s, data_h;
    logic unused_hist;

    i2s_edge_sync #(.RST_VAL(1'b1)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .sig_in(I2S_sclk), .sig_sync(sclk_s), .sig_hist(sclk_h));
    i2s_edge_sync #(.RST_VAL(1'b1)) u_sync_ws (
        .clk(clk), .rst_n(rst_n), .sig_in(I2S_ws), .sig_sync(ws_s), .sig_hist(ws_h));
    i2s_edge_sync #(.RST_VAL(1'b0)) u_sync_data (
        .clk(clk), .rst_n(rst_n), .sig_in(I2S_data), .sig_sync(data_s), .sig_hist(data_h));

    assign unused_hist = ws_h ^ data_h;

    rx_state_e         state_q, state_d;
    logic              ws_last_q, ws_last_d;
    logic              ws_ok_q, ws_ok_d;
    logic [SMPL_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SMPL_W-1:0] lft_q, lft_d;
    logic [SMPL_W-1:0] rght_q, rght_d;
    logic              rdone_q, rdone_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;

    logic              sclk_rise, ws_rise, ws_fall, ws_edge, last_bit;
    logic [SMPL_W-1:0] shift_val;

    // The first sampled ws after reset only seeds the history, so a reset
    // released mid-slot never fakes a slot boundary.
    always_comb begin
        sclk_rise = sclk_s & ~sclk_h;
        ws_rise   = sclk_rise & ws_ok_q & ~ws_last_q & ws_s;
        ws_fall   = sclk_rise & ws_ok_q & ws_last_q & ~ws_s;
        ws_edge   = ws_rise | ws_fall;
        shift_val = {shreg_q[SMPL_W-2:0], data_s};
        last_bit  = (cnt_q == CNT_W'(SMPL_W - 1));
    end

    always_comb begin
        state_d   = state_q;
        ws_last_d = ws_last_q;
        ws_ok_d   = ws_ok_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        lft_d     = lft_q;
        rght_d    = rght_q;
        rdone_d   = 1'b0;
        vld_d     = rdone_q;
        err_d     = 1'b0;

        if (sclk_rise) begin
            ws_last_d = ws_s;
            ws_ok_d   = 1'b1;
        end

        case (state_q)
            ST_SYNC: begin
                if (ws_fall) state_d = ST_SKIP_L;
            end
            ST_SKIP_L, ST_SKIP_R: begin
                if (sclk_rise) begin
                    state_d = (state_q == ST_SKIP_L) ? ST_LEFT : ST_RIGHT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            ST_LEFT, ST_RIGHT: begin
                if (ws_edge) begin
                    err_d   = 1'b1;
                    state_d = ST_SYNC;
                    cnt_d   = '0;
                    shreg_d = '0;
                end else if (sclk_rise) begin
                    shreg_d = shift_val;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_bit) begin
                        if (state_q == ST_LEFT) begin
                            lft_d   = shift_val;
                            state_d = ST_WAIT_R;
                        end else begin
                            rght_d  = shift_val;
                            rdone_d = 1'b1;
                            state_d = ST_WAIT_L;
                        end
                    end
                end
            end
            ST_WAIT_R: begin
                if (ws_rise) begin
                    state_d = ST_SKIP_R;
                end else if (ws_fall) begin
                    err_d   = 1'b1;
                    state_d = ST_SYNC;
                end
            end
            ST_WAIT_L: begin
                if (ws_fall) begin
                    state_d = ST_SKIP_L;
                end else if (ws_rise) begin
                    err_d   = 1'b1;
                    state_d = ST_SYNC;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SYNC;
            ws_last_q <= 1'b1;
            ws_ok_q   <= 1'b0;
            shreg_q   <= '0;
            cnt_q     <= '0;
            lft_q     <= '0;
            rght_q    <= '0;
            rdone_q   <= 1'b0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ws_last_q <= ws_last_d;
            ws_ok_q   <= ws_ok_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            lft_q     <= lft_d;
            rght_q    <= rght_d;
            rdone_q   <= rdone_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
        end
    end

    assign lft_chnnl  = lft_q;
    assign rght_chnnl = rght_q;
    assign vld        = vld_q;
    assign sync_err   = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - directed self-checking bench for i2s_rx driven by an RN52-style frame generator
module tb_i2s_rx;
    import i2s_rx_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b1;
    logic        ws = 1'b1;
    logic        data = 1'b0;
    logic [23:0] lft, rght;
    logic        vld, sync_err;

    i2s_rx #(.SMPL_W(24), .SLOT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .I2S_sclk(sclk), .I2S_ws(ws), .I2S_data(data),
        .lft_chnnl(lft), .rght_chnnl(rght), .vld(vld), .sync_err(sync_err));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          cyc = 0, vld_cnt = 0, err_cnt = 0, last_vld_cyc = 0;
    int          per_cnt = 0, per_bad = 0;
    int          half = 16, meas_start = 0;
    bit          meas_en = 1'b0;
    logic [23:0] vld_l = '0, vld_r = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sync_err) err_cnt <= err_cnt + 1;
        if (vld) begin
            vld_cnt <= vld_cnt + 1;
            vld_l   <= lft;
            vld_r   <= rght;
            if (meas_en && last_vld_cyc > meas_start) begin
                per_cnt <= per_cnt + 1;
                if ((cyc - last_vld_cyc) < 128 * half - 1 || (cyc - last_vld_cyc) > 128 * half + 1)
                    per_bad <= per_bad + 1;
            end
            last_vld_cyc <= cyc;
        end
    end

    logic [23:0] snap_l, snap_r;
    logic        snap_v;
    logic [2:0]  snap_st;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One serial bit: ws/data change with the sclk fall, receiver samples on the rise.
    task automatic send_bit(input logic ws_v, input logic d_v, input bit pulse);
        sclk = 1'b0;
        ws   = ws_v;
        data = d_v;
        if (pulse) begin
            tick(1);
            rst_n = 1'b0;
            @(negedge clk);
            snap_l  = lft;
            snap_r  = rght;
            snap_v  = vld;
            snap_st = dut.state_q;
            tick(1);
            rst_n = 1'b1;
            tick(half - 2);
        end else begin
            tick(half);
        end
        sclk = 1'b1;
        tick(half);
    endtask

    // Slot bit 0 carries the ws edge, bit 1 is the one-bclk delay, bits 2..25 the sample MSB first.
    function automatic logic slot_bit(input logic [23:0] s, input int b);
        if (b >= 2 && b <= 25) return s[25 - b];
        return 1'b0;
    endfunction

    task automatic rn52_frame(input logic [23:0] l, input logic [23:0] r,
                              input int rel, input int llen, input int pbit);
        for (int b = 0; b < llen; b++) begin
            if (b == rel) rst_n = 1'b1;
            send_bit(1'b0, slot_bit(l, b), 1'b0);
        end
        for (int b = 0; b < 32; b++) send_bit(1'b1, slot_bit(r, b), b == pbit);
    endtask

    int v0, e0, p0, pb0;

    initial begin
        tick(4);
        chk_eq("rst_lft", lft, 24'h0);
        chk_eq("rst_rght", rght, 24'h0);
        chk_eq("rst_vld", vld, 1'b0);
        chk_eq("rst_sync_err", sync_err, 1'b0);
        chk_eq("rst_state", dut.state_q, ST_SYNC);
        rst_n = 1'b1;
        tick(2);

        // Two nominal frames at sclk = clk/32
        half = 16;
        v0 = vld_cnt; e0 = err_cnt;
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        rn52_frame(24'h5A5A5A, 24'hA5A5A5, -1, 32, -1);
        rn52_frame(24'h5A5A5A, 24'hA5A5A5, -1, 32, -1);
        tick(4);
        chk_eq("nom_lft", lft, 24'h5A5A5A);
        chk_eq("nom_rght", rght, 24'hA5A5A5);
        chk_eq("nom_vld_cnt", vld_cnt - v0, 2);
        chk_eq("nom_err_cnt", err_cnt - e0, 0);

        // Continuous stream: vld period is one frame of 64 sclk periods
        v0 = vld_cnt; e0 = err_cnt; p0 = per_cnt; pb0 = per_bad;
        meas_start = cyc; meas_en = 1'b1;
        for (int f = 0; f < 3; f++) rn52_frame(24'h13A5C7, 24'hFEDCBA, -1, 32, -1);
        tick(4);
        meas_en = 1'b0;
        chk_eq("rn52_vld_cnt", vld_cnt - v0, 3);
        chk_eq("rn52_periods", per_cnt - p0, 2);
        chk_eq("rn52_period_bad", per_bad - pb0, 0);
        chk_eq("rn52_err_cnt", err_cnt - e0, 0);
        chk_eq("rn52_rght", rght, 24'hFEDCBA);

        // Reset released mid-left-slot: partial frame must not produce vld
        half = 4;
        rst_n = 1'b0;
        tick(2);
        v0 = vld_cnt; e0 = err_cnt;
        rn52_frame(24'h123456, 24'h654321, 8, 32, -1);
        tick(4);
        chk_eq("midrst_vld_cnt", vld_cnt - v0, 0);
        chk_eq("midrst_lft", lft, 24'h0);
        rn52_frame(24'h13579B, 24'h2468AC, -1, 32, -1);
        tick(4);
        chk_eq("midrst_first_vld_cnt", vld_cnt - v0, 1);
        chk_eq("midrst_vld_lft", vld_l, 24'h13579B);
        chk_eq("midrst_vld_rght", vld_r, 24'h2468AC);
        chk_eq("midrst_err_cnt", err_cnt - e0, 0);

        // ws rises after only 10 left bits
        v0 = vld_cnt; e0 = err_cnt;
        rn52_frame(24'hFFFFFF, 24'h000000, -1, 12, -1);
        tick(4);
        chk_eq("short_err_cnt", err_cnt - e0, 1);
        chk_eq("short_vld_cnt", vld_cnt - v0, 0);
        chk_eq("short_lft_hold", lft, 24'h13579B);
        chk_eq("short_rght_hold", rght, 24'h2468AC);
        rn52_frame(24'h000001, 24'hFFFFFF, -1, 32, -1);
        tick(4);
        chk_eq("resync_lft", lft, 24'h000001);
        chk_eq("resync_rght", rght, 24'hFFFFFF);
        chk_eq("resync_vld_cnt", vld_cnt - v0, 1);
        chk_eq("resync_err_cnt", err_cnt - e0, 1);

        // 100 back-to-back frames with full-scale values
        v0 = vld_cnt; e0 = err_cnt; p0 = per_cnt; pb0 = per_bad;
        meas_start = cyc; meas_en = 1'b1;
        for (int f = 0; f < 100; f++) rn52_frame(24'h800000, 24'h7FFFFF, -1, 32, -1);
        tick(4);
        meas_en = 1'b0;
        chk_eq("burst_vld_cnt", vld_cnt - v0, 100);
        chk_eq("burst_err_cnt", err_cnt - e0, 0);
        chk_eq("burst_lft", lft, 24'h800000);
        chk_eq("burst_rght", rght, 24'h7FFFFF);
        chk_eq("burst_periods", per_cnt - p0, 99);
        chk_eq("burst_period_bad", per_bad - pb0, 0);

        // One-clk reset pulse while receiving the right sample
        v0 = vld_cnt; e0 = err_cnt;
        rn52_frame(24'hAAAAAA, 24'h555555, -1, 32, 10);
        chk_eq("pulse_lft", snap_l, 24'h0);
        chk_eq("pulse_rght", snap_r, 24'h0);
        chk_eq("pulse_vld", snap_v, 1'b0);
        chk_eq("pulse_state", snap_st, ST_SYNC);
        chk_eq("pulse_no_vld", vld_cnt - v0, 0);
        rn52_frame(24'hABCDEF, 24'h123456, -1, 32, -1);
        tick(4);
        chk_eq("recover_lft", lft, 24'hABCDEF);
        chk_eq("recover_rght", rght, 24'h123456);
        chk_eq("recover_vld_cnt", vld_cnt - v0, 1);
        chk_eq("recover_err_cnt", err_cnt - e0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
